pixel_write_scheduler: RTL and testbench
========================================

Name: pixel_write_scheduler

Overview:
Sits between the host instruction stream and the 3-bit-per-cell screen buffer (600 cells, 30x20 grid) used by the pixel generator. Decodes SET_PIXEL and CLEAR_SCREEN instructions and queues pixel writes in a small FIFO. Issues writes to the buffer's single write port only while the write window (blanking) is open, so scan-out reads never collide with host updates. A CLEAR_SCREEN sweep is sequenced by an internal state machine.

Parameters:
DEPTH, 8, pixel-write FIFO entries; power of 2, >=2
ADDR_W, 10, screen buffer address width
PIX_W, 3, palette index width per cell
CELLS, 600, valid cell count; addresses >= CELLS are rejected

Ports:
i_clk  in  1  system clock
i_reset_n  in  1  asynchronous active-low reset
i_instruction  in  32  [7:0] opcode, [31:8] args
i_instruction_ready  in  1  single-cycle strobe; instruction valid this cycle
i_write_window  in  1  high while the buffer write port may be used (hsync/vsync blanking)
o_wr_en  out  1  buffer write strobe
o_wr_addr  out  ADDR_W  buffer write address
o_wr_data  out  PIX_W  palette index to write
o_busy  out  1  FIFO full or clear sweep active
o_overflow  out  1  1-cycle pulse: SET_PIXEL dropped because FIFO full
o_bad_addr  out  1  1-cycle pulse: SET_PIXEL address >= CELLS, dropped
o_fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async assert, sync deassert handled upstream): all outputs 0, FIFO empty, state IDLE, clear counter 0.
- Stage 1: instruction and ready registered on every i_clk edge; instruction register cleared to 0 when ready low.
- Decode (registered stage):
  - 0x07 SET_PIXEL: addr = args[9:0], data = args[12:10].
  - 0x08 CLEAR_SCREEN: colour = args[2:0].
  - All other opcodes (incl. 0x01-0x06 bg colour ops) ignored, no response.
- SET_PIXEL enqueue, one cycle after registration:
  - addr >= CELLS -> o_bad_addr pulse, nothing queued.
  - FIFO full -> o_overflow pulse, entry dropped, FIFO unchanged.
  - Otherwise pushed; o_fifo_level increments next cycle.
  - Push and pop in the same cycle: level unchanged; full FIFO with a pop that same cycle accepts the push (no overflow).
- State machine:
  - IDLE: FIFO non-empty -> DRAIN. CLEAR_SCREEN decoded -> CLEAR (addr counter = 0, colour latched).
  - DRAIN: each cycle with i_write_window=1, pop head and drive o_wr_en=1, o_wr_addr/o_wr_data = head for exactly that cycle. FIFO empties -> IDLE. CLEAR_SCREEN decoded -> CLEAR after the current cycle's pop; remaining FIFO entries held.
  - CLEAR: each cycle with i_write_window=1, write colour to counter address, counter+1. Counter == CELLS-1 written -> IDLE (remaining FIFO entries then drain in original order). New SET_PIXEL during CLEAR still queued.
  - CLEAR_SCREEN during CLEAR restarts the sweep at 0 with the new colour.
- Window closed: no writes; state, counter and FIFO hold. Window can toggle every cycle; each open cycle yields at most one write.
- At most one o_wr_en per cycle. Write outputs are registered; o_wr_addr/o_wr_data hold last value when o_wr_en=0.
- o_busy = FIFO full OR state == CLEAR.
- Latency: instruction strobe at cycle N -> earliest o_wr_en at N+3 (register, decode/push, pop), window open.
- Reset asserted mid-sweep or mid-drain: sweep abandoned, FIFO flushed, outputs 0 immediately.

Test Plan:
- Window held 1; SET_PIXEL args addr=5, data=3 (instr 0x00000C0507) at cycle N -> single o_wr_en at N+3, addr=5, data=3; level returns to 0.
- Window 0; 9 SET_PIXELs with DEPTH=8 -> level=8, o_busy=1, one o_overflow pulse on the 9th; open window -> 8 writes in issue order on consecutive cycles.
- SET_PIXEL addr=600 and addr=1023 -> two o_bad_addr pulses, no writes, level stays 0; addr=599 accepted.
- CLEAR_SCREEN colour=2, window toggling 1/0 each cycle -> exactly 600 writes, addrs 0..599 ascending, data=2, ~1200 cycles, o_busy high throughout, then IDLE.
- CLEAR colour=1 with 3 queued SET_PIXELs, second CLEAR colour=4 at sweep addr 100 -> sweep restarts at 0 with data 4; the 3 queued writes issue after addr 599.
- Reset pulsed low during sweep at addr 300 -> o_wr_en/o_busy drop to 0 immediately, level=0; a later SET_PIXEL completes normally.

Source files
------------

// File: rtl/pixel_write_scheduler.sv
// Queues host SET_PIXEL writes and sequences CLEAR_SCREEN sweeps into the
// screen buffer write port, issuing writes only while the blanking window is open.
module pixel_write_scheduler #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 10,
  parameter int PIX_W  = 3,
  parameter int CELLS  = 600
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic [31:0]                i_instruction,
  input  logic                       i_instruction_ready,
  input  logic                       i_write_window,
  output logic                       o_wr_en,
  output logic [ADDR_W-1:0]          o_wr_addr,
  output logic [PIX_W-1:0]           o_wr_data,
  output logic                       o_busy,
  output logic                       o_overflow,
  output logic                       o_bad_addr,
  output logic [$clog2(DEPTH):0]     o_fifo_level
);

  // state | meaning
  // IDLE  | nothing to do; waiting for queued pixels or a clear
  // DRAIN | popping queued pixel writes on open window cycles
  // CLEAR | sweeping every cell with the latched colour
  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int LVL_W    = PTR_W + 1;
  localparam int ENTRY_W  = ADDR_W + PIX_W;
  localparam int DATA_LSB = 8 + ADDR_W;
  localparam logic [7:0] OP_SET_PIXEL    = 8'h07;
  localparam logic [7:0] OP_CLEAR_SCREEN = 8'h08;
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W:0]   CELL_LIMIT = (ADDR_W + 1)'(CELLS);

  logic [31:0]        instr_q;
  logic               ready_q;
  logic               set_cmd, clear_cmd, addr_ok;
  logic [ADDR_W-1:0]  set_addr;
  logic [PIX_W-1:0]   set_data, clear_colour;
  logic               unused_instr_bits;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [LVL_W-1:0]   level, level_next;
  logic               full, empty, push, pop;
  logic [ENTRY_W-1:0] head;

  state_t             state, state_next;
  logic [ADDR_W-1:0]  cnt;
  logic [PIX_W-1:0]   colour;
  logic               cnt_clr, sweep_wr;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      instr_q <= '0;
      ready_q <= 1'b0;
    end else begin
      instr_q <= i_instruction_ready ? i_instruction : '0;
      ready_q <= i_instruction_ready;
    end
  end

  assign set_cmd      = ready_q && (instr_q[7:0] == OP_SET_PIXEL);
  assign clear_cmd    = ready_q && (instr_q[7:0] == OP_CLEAR_SCREEN);
  assign set_addr     = instr_q[8 +: ADDR_W];
  assign set_data     = instr_q[DATA_LSB +: PIX_W];
  assign clear_colour = instr_q[8 +: PIX_W];
  assign addr_ok      = {1'b0, set_addr} < CELL_LIMIT;
  assign unused_instr_bits = ^instr_q[31:DATA_LSB+PIX_W];

  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);
  assign head  = mem[rd_ptr];
  assign pop   = (state == DRAIN) && i_write_window && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push  = set_cmd && addr_ok && (!full || pop);

  always_comb begin
    level_next = level;
    case ({push, pop})
      2'b10:   level_next = level + LVL_W'(1);
      2'b01:   level_next = level - LVL_W'(1);
      default: level_next = level;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= {set_addr, set_data};
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    sweep_wr   = 1'b0;
    case (state)
      IDLE: begin
        if (clear_cmd) begin
          state_next = CLEAR;
          cnt_clr    = 1'b1;
        end else if (!empty) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (clear_cmd) begin
          state_next = CLEAR;
          cnt_clr    = 1'b1;
        end else if (level_next == '0) begin
          state_next = IDLE;
        end
      end
      CLEAR: begin
        sweep_wr = i_write_window;
        if (clear_cmd) cnt_clr = 1'b1;
        else if (i_write_window && (cnt == LAST_CELL)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A restart still completes the current cell with the old colour.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt    <= '0;
      colour <= '0;
    end else begin
      if (cnt_clr)       cnt <= '0;
      else if (sweep_wr) cnt <= cnt + ADDR_W'(1);
      if (clear_cmd) colour <= clear_colour;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_wr_en    <= 1'b0;
      o_wr_addr  <= '0;
      o_wr_data  <= '0;
      o_overflow <= 1'b0;
      o_bad_addr <= 1'b0;
    end else begin
      o_wr_en    <= pop || sweep_wr;
      o_overflow <= set_cmd && addr_ok && full && !pop;
      o_bad_addr <= set_cmd && !addr_ok;
      if (pop) begin
        o_wr_addr <= head[ENTRY_W-1:PIX_W];
        o_wr_data <= head[PIX_W-1:0];
      end else if (sweep_wr) begin
        o_wr_addr <= cnt;
        o_wr_data <= colour;
      end
    end
  end

  assign o_busy       = full || (state == CLEAR);
  assign o_fifo_level = level;

endmodule

// File: tb/tb_pixel_write_scheduler.sv
// Directed bench for pixel_write_scheduler: pixel writes, overflow, bad address,
// clear sweeps with a toggling window, restart and mid-sweep reset.
module tb_pixel_write_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        rdy = 1'b0;
  logic        win = 1'b0;
  logic        wr_en, busy, ovf, bad;
  logic [9:0]  wr_addr;
  logic [2:0]  wr_data;
  logic [3:0]  level;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int wa[$], wd[$], wc[$];
  int ovf_cnt = 0, bad_cnt = 0;

  pixel_write_scheduler #(.DEPTH(8), .ADDR_W(10), .PIX_W(3), .CELLS(600)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_instruction(instr),
    .i_instruction_ready(rdy), .i_write_window(win),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_busy(busy), .o_overflow(ovf), .o_bad_addr(bad), .o_fifo_level(level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (wr_en) begin
      wa.push_back(int'(wr_addr));
      wd.push_back(int'(wr_data));
      wc.push_back(cyc);
    end
    if (ovf) ovf_cnt++;
    if (bad) bad_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] set_px(input logic [9:0] a, input logic [2:0] d);
    return {11'b0, d, a, 8'h07};
  endfunction

  function automatic logic [31:0] clr_cmd(input logic [2:0] c);
    return {21'b0, c, 8'h08};
  endfunction

  task automatic send(input logic [31:0] v);
    instr = v;
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    instr = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic flush_log();
    wa.delete(); wd.delete(); wc.delete();
    ovf_cnt = 0; bad_cnt = 0;
  endtask

  initial begin
    int errs, f, drop;
    bit fin, sent4;

    @(negedge clk);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_bad", bad, 0);
    chk("rst_level", level, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single pixel, window open: write appears three edges after the strobe
    win = 1'b1;
    send(set_px(10'd5, 3'd3));
    chk("t1_en_n1", wr_en, 0);
    @(negedge clk); chk("t1_level_push", level, 1);
    @(negedge clk); chk("t1_en_n2", wr_en, 0);
    @(negedge clk);
    chk("t1_en_n3", wr_en, 1);
    chk("t1_addr", wr_addr, 5);
    chk("t1_data", wr_data, 3);
    chk("t1_level_pop", level, 0);
    @(negedge clk); chk("t1_en_n4", wr_en, 0);
    chk("t1_addr_hold", wr_addr, 5);

    // fill with window closed, overflow on ninth, then drain in order
    idle(2); flush_log();
    win = 1'b0;
    for (int i = 0; i < 9; i++) send(set_px(10'(10 + i), 3'(i % 8)));
    idle(3);
    chk("t2_level_full", level, 8);
    chk("t2_busy_full", busy, 1);
    chk("t2_ovf_pulses", ovf_cnt, 1);
    chk("t2_no_writes_closed", wa.size(), 0);
    win = 1'b1;
    idle(12);
    chk("t2_write_count", wa.size(), 8);
    if (wa.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("t2_addr", wa[i], 10 + i);
        chk("t2_data", wd[i], i);
      end
      chk("t2_consecutive", wc[7] - wc[0], 7);
    end
    chk("t2_level_empty", level, 0);
    chk("t2_busy_idle", busy, 0);

    // out-of-range addresses rejected, last valid cell accepted
    flush_log();
    send(set_px(10'd600, 3'd1));
    send(set_px(10'd1023, 3'd2));
    idle(3);
    chk("t3_level", level, 0);
    chk("t3_bad_pulses", bad_cnt, 2);
    chk("t3_no_writes", wa.size(), 0);
    send(set_px(10'd599, 3'd5));
    idle(5);
    chk("t3_write_count", wa.size(), 1);
    if (wa.size() == 1) begin
      chk("t3_addr", wa[0], 599);
      chk("t3_data", wd[0], 5);
    end
    chk("t3_bad_after", bad_cnt, 2);

    // clear sweep with window toggling every cycle
    flush_log();
    win = 1'b0;
    send(clr_cmd(3'd2));
    @(negedge clk);
    fin = 0; drop = 0;
    for (int k = 0; k < 1500 && !fin; k++) begin
      @(negedge clk);
      win = ~win;
      if (wr_en && wr_addr == 10'd599) fin = 1;
      else if (!busy) drop++;
    end
    win = 1'b1;
    idle(3);
    chk("t4_finished", fin, 1);
    chk("t4_busy_drops", drop, 0);
    chk("t4_write_count", wa.size(), 600);
    errs = 0;
    for (int i = 0; i < wa.size(); i++) if (wa[i] != i || wd[i] != 2) errs++;
    chk("t4_seq_errors", errs, 0);
    if (wa.size() == 600) chk("t4_span", wc[599] - wc[0], 1198);
    chk("t4_busy_end", busy, 0);
    chk("t4_level_end", level, 0);

    // clear with queued pixels, restart with new colour at address 100
    flush_log();
    send(clr_cmd(3'd1));
    send(set_px(10'd20, 3'd6));
    send(set_px(10'd30, 3'd7));
    send(set_px(10'd40, 3'd5));
    sent4 = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (sent4 && !busy && level == 0 && !wr_en) break;
      if (!sent4 && wr_en && wr_addr == 10'd100 && wr_data == 3'd1) begin
        instr = clr_cmd(3'd4);
        rdy = 1'b1;
        sent4 = 1;
      end else begin
        instr = '0;
        rdy = 1'b0;
      end
    end
    rdy = 1'b0; instr = '0;
    idle(2);
    chk("t5_restart_sent", sent4, 1);
    f = -1;
    for (int i = 0; i < wa.size(); i++) if (f < 0 && wd[i] == 4) f = i;
    chk("t5_restart_idx", f, 103);
    chk("t5_write_count", wa.size(), f + 603);
    if (f >= 0 && wa.size() == f + 603) begin
      errs = 0;
      for (int i = 0; i < f; i++) if (wa[i] != i || wd[i] != 1) errs++;
      chk("t5_first_sweep_err", errs, 0);
      errs = 0;
      for (int j = 0; j < 600; j++) if (wa[f + j] != j || wd[f + j] != 4) errs++;
      chk("t5_second_sweep_err", errs, 0);
      chk("t5_q0_addr", wa[f + 600], 20); chk("t5_q0_data", wd[f + 600], 6);
      chk("t5_q1_addr", wa[f + 601], 30); chk("t5_q1_data", wd[f + 601], 7);
      chk("t5_q2_addr", wa[f + 602], 40); chk("t5_q2_data", wd[f + 602], 5);
    end

    // reset mid-sweep at address 300
    flush_log();
    send(clr_cmd(3'd3));
    send(set_px(10'd50, 3'd2));
    send(set_px(10'd51, 3'd2));
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (wr_en && wr_addr == 10'd300) break;
    end
    chk("t6_reached_300", wr_addr, 300);
    chk("t6_level_before", level, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_wr_en", wr_en, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_level", level, 0);
    chk("t6_rst_addr", wr_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    flush_log();
    idle(2);
    send(set_px(10'd7, 3'd4));
    idle(6);
    chk("t6_post_count", wa.size(), 1);
    if (wa.size() == 1) begin
      chk("t6_post_addr", wa[0], 7);
      chk("t6_post_data", wd[0], 4);
    end
    chk("t6_post_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
